// File: rtl/datapath_pkg.sv
// Shared encodings and the issue-stage bundle for the
// two-stage SIMD datapath.
package datapath_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  localparam logic [1:0] VEC_W = 2'b00;
  localparam logic [1:0] VEC_H = 2'b01;
  localparam logic [1:0] VEC_B = 2'b10;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] vec;
    logic [1:0] write;
    logic       const_a;
  } s1_ctrl_t;

endpackage

// File: rtl/datapath_pipelined_simd_alu.sv
// Combinational lane-partitioned ALU; carries and shifts
// stay inside the selected lane width.
module simd_alu
  import datapath_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        op_i,
  input  logic [1:0]        vec_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] y_o
);

  localparam int SH_W = $clog2(DATA_W);

  function automatic logic [DATA_W-1:0] f_w(
    input logic [2:0]        o,
    input logic [DATA_W-1:0] x,
    input logic [DATA_W-1:0] y
  );
    logic [DATA_W-1:0] r;
    case (o)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_SHL:  r = x << y[SH_W-1:0];
      OP_SHR:  r = x >> y[SH_W-1:0];
      default: r = x;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] f_h(
    input logic [2:0]  o,
    input logic [15:0] x,
    input logic [15:0] y
  );
    logic [15:0] r;
    case (o)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_SHL:  r = x << y[3:0];
      OP_SHR:  r = x >> y[3:0];
      default: r = x;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] f_b(
    input logic [2:0] o,
    input logic [7:0] x,
    input logic [7:0] y
  );
    logic [7:0] r;
    case (o)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_SHL:  r = x << y[2:0];
      OP_SHR:  r = x >> y[2:0];
      default: r = x;
    endcase
    return r;
  endfunction

  logic [DATA_W-1:0] y_w;
  logic [DATA_W-1:0] y_h;
  logic [DATA_W-1:0] y_b;

  assign y_w = f_w(op_i, a_i, b_i);

  for (genvar i = 0; i < DATA_W / 16; i++) begin : g_h
    assign y_h[i*16 +: 16] =
      f_h(op_i, a_i[i*16 +: 16], b_i[i*16 +: 16]);
  end

  for (genvar i = 0; i < DATA_W / 8; i++) begin : g_b
    assign y_b[i*8 +: 8] =
      f_b(op_i, a_i[i*8 +: 8], b_i[i*8 +: 8]);
  end

  // Encoding 11 falls through to a single full-width lane.
  always_comb begin
    y_o = y_w;
    case (vec_i)
      VEC_H:   y_o = y_h;
      VEC_B:   y_o = y_b;
      default: y_o = y_w;
    endcase
  end

endmodule

// File: rtl/datapath_pipelined.sv
// Two-stage register-file datapath: issue, then execute into a
// result stage that writes back on the output handshake.
module datapath_pipelined
  import datapath_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 16,
  parameter int ADDR_W  = 4,
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [1:0]        vec,
  input  logic [ADDR_W-1:0] A,
  input  logic [ADDR_W-1:0] B,
  input  logic [ADDR_W-1:0] C,
  input  logic [ADDR_W-1:0] D,
  input  logic [ADDR_W-1:0] Y1,
  input  logic [ADDR_W-1:0] Y2,
  input  logic [1:0]        write,
  input  logic              const_a,
  input  logic [DATA_W-1:0] constant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] y1_data,
  output logic [DATA_W-1:0] y2_data
);

  logic              s1_valid_q;
  logic              s1_valid_d;
  s1_ctrl_t          s1_ctrl_q;
  logic [ADDR_W-1:0] s1_a_q;
  logic [ADDR_W-1:0] s1_b_q;
  logic [ADDR_W-1:0] s1_c_q;
  logic [ADDR_W-1:0] s1_d_q;
  logic [ADDR_W-1:0] s1_y1_q;
  logic [ADDR_W-1:0] s1_y2_q;
  logic [DATA_W-1:0] s1_k_q;

  logic              s2_valid_q;
  logic              s2_valid_d;
  logic [DATA_W-1:0] s2_r1_q;
  logic [DATA_W-1:0] s2_r2_q;
  logic [ADDR_W-1:0] s2_y1_q;
  logic [ADDR_W-1:0] s2_y2_q;
  logic [1:0]        s2_wr_q;

  logic [DATA_W-1:0] rf_q [NREGS];

  logic              out_fire;
  logic              s1_advance;
  logic              in_fire;
  logic              wr1;
  logic              wr2;
  logic [ADDR_W-1:0] src [4];
  logic [DATA_W-1:0] opnd [4];
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_y1;
  logic [DATA_W-1:0] alu_y2;

  // Addresses that are out of range or the hardwired zero
  // register neither read nor write real storage.
  function automatic logic addr_ok(
    input logic [ADDR_W-1:0] ad
  );
    return (int'(ad) < NREGS) &&
           !((ZERO_R0 != 0) && (ad == '0));
  endfunction

  assign out_fire   = s2_valid_q && out_ready;
  assign s1_advance = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready   = rst_n && (!s1_valid_q || s1_advance);
  assign in_fire    = in_valid && in_ready;

  assign wr1 = out_fire && s2_wr_q[0] && addr_ok(s2_y1_q);
  assign wr2 = out_fire && s2_wr_q[1] && addr_ok(s2_y2_q);

  assign src[0] = s1_a_q;
  assign src[1] = s1_b_q;
  assign src[2] = s1_c_q;
  assign src[3] = s1_d_q;

  // Y2 is checked first so the bypass agrees with writeback order.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      opnd[i] = '0;
      if (addr_ok(src[i])) begin
        if (wr2 && src[i] == s2_y2_q)
          opnd[i] = s2_r2_q;
        else if (wr1 && src[i] == s2_y1_q)
          opnd[i] = s2_r1_q;
        else
          opnd[i] = rf_q[src[i]];
      end
    end
  end

  assign alu_a = s1_ctrl_q.const_a ? s1_k_q : opnd[0];

  simd_alu #(.DATA_W(DATA_W)) u_alu1 (
    .op_i  (s1_ctrl_q.op),
    .vec_i (s1_ctrl_q.vec),
    .a_i   (alu_a),
    .b_i   (opnd[1]),
    .y_o   (alu_y1)
  );

  simd_alu #(.DATA_W(DATA_W)) u_alu2 (
    .op_i  (s1_ctrl_q.op),
    .vec_i (s1_ctrl_q.vec),
    .a_i   (opnd[2]),
    .b_i   (opnd[3]),
    .y_o   (alu_y2)
  );

  assign s1_valid_d = in_ready ? in_valid : s1_valid_q;
  assign s2_valid_d = s1_advance ? 1'b1 :
                      out_fire   ? 1'b0 : s2_valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_ctrl_q  <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_c_q     <= '0;
      s1_d_q     <= '0;
      s1_y1_q    <= '0;
      s1_y2_q    <= '0;
      s1_k_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_r1_q    <= '0;
      s2_r2_q    <= '0;
      s2_y1_q    <= '0;
      s2_y2_q    <= '0;
      s2_wr_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (in_fire) begin
        s1_ctrl_q <= '{op: op, vec: vec, write: write,
                       const_a: const_a};
        s1_a_q    <= A;
        s1_b_q    <= B;
        s1_c_q    <= C;
        s1_d_q    <= D;
        s1_y1_q   <= Y1;
        s1_y2_q   <= Y2;
        s1_k_q    <= constant;
      end
      if (s1_advance) begin
        s2_r1_q <= alu_y1;
        s2_r2_q <= alu_y2;
        s2_y1_q <= s1_y1_q;
        s2_y2_q <= s1_y2_q;
        s2_wr_q <= s1_ctrl_q.write;
      end
    end
  end

  // The later Y2 assignment wins when both target one register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        rf_q[i] <= '0;
    end else begin
      if (wr1)
        rf_q[s2_y1_q] <= s2_r1_q;
      if (wr2)
        rf_q[s2_y2_q] <= s2_r2_q;
    end
  end

  assign out_valid = s2_valid_q;
  assign y1_data   = s2_r1_q;
  assign y2_data   = s2_r2_q;

endmodule

// File: tb/tb_datapath_pipelined.sv
// Scoreboard bench: drivers push hand-computed results,
// a negedge monitor pops and compares on each output handshake.
module tb_datapath_pipelined;
  import datapath_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    op;
  logic [1:0]    vec;
  logic [AW-1:0] A, B, C, D, Y1, Y2;
  logic [1:0]    write;
  logic          const_a;
  logic [DW-1:0] constant;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] y1_data;
  logic [DW-1:0] y2_data;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [2*DW-1:0] exp_q[$];
  int fire_cyc[$];
  logic [2*DW-1:0] mon_e;

  datapath_pipelined #(
    .DATA_W(DW), .NREGS(16), .ADDR_W(AW), .ZERO_R0(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .vec(vec),
    .A(A), .B(B), .C(C), .D(D), .Y1(Y1), .Y2(Y2),
    .write(write), .const_a(const_a), .constant(constant),
    .out_valid(out_valid), .out_ready(out_ready),
    .y1_data(y1_data), .y2_data(y2_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      fire_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected output: got %h %h want none",
                 y1_data, y2_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("y1_data", y1_data, mon_e[2*DW-1:DW]);
        chk("y2_data", y2_data, mon_e[DW-1:0]);
      end
    end
  end

  task automatic set_in(
    input logic [2:0] o, input logic [1:0] v,
    input logic [AW-1:0] a, input logic [AW-1:0] b,
    input logic [AW-1:0] c, input logic [AW-1:0] d,
    input logic [AW-1:0] y1, input logic [AW-1:0] y2,
    input logic [1:0] w, input logic ca,
    input logic [DW-1:0] k);
    op = o; vec = v; A = a; B = b; C = c; D = d;
    Y1 = y1; Y2 = y2; write = w; const_a = ca; constant = k;
  endtask

  task automatic issue(
    input logic [2:0] o, input logic [1:0] v,
    input logic [AW-1:0] a, input logic [AW-1:0] b,
    input logic [AW-1:0] c, input logic [AW-1:0] d,
    input logic [AW-1:0] y1, input logic [AW-1:0] y2,
    input logic [1:0] w, input logic ca,
    input logic [DW-1:0] k,
    input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    logic ok;
    ok = 1'b0;
    set_in(o, v, a, b, c, d, y1, y2, w, ca, k);
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL issue timeout: in_ready got 0 want 1");
    end else begin
      exp_q.push_back({e1, e2});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] r,
                    input logic [DW-1:0] v);
    issue(OP_PASS, VEC_W, 4'd0, 4'd0, 4'd0, 4'd0, r, 4'd0,
          2'b01, 1'b1, v, v, 32'd0);
  endtask

  task automatic rd(input logic [AW-1:0] r,
                    input logic [DW-1:0] e);
    issue(OP_PASS, VEC_W, r, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
          2'b00, 1'b0, 32'd0, e, 32'd0);
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++)
      @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain timeout: got %0d pending want 0",
               exp_q.size());
    end
  endtask

  logic [DW-1:0] sk [3];
  logic [AW-1:0] sy [3];
  int acc;
  int nz;

  initial begin
    sk = '{32'd11, 32'd12, 32'd13};
    sy = '{4'd5, 4'd6, 4'd7};
    set_in(OP_PASS, VEC_W, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
           2'b00, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset y1_data", y1_data, 32'd0);
    chk("reset y2_data", y2_data, 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;

    // r1=5, then ADD r1+r1 back-to-back through the bypass
    wr(4'd1, 32'd5);
    chk("latency edge N", 32'(out_valid), 32'd0);
    issue(OP_ADD, VEC_W, 4'd1, 4'd1, 4'd0, 4'd0, 4'd3, 4'd0,
          2'b01, 1'b0, 32'd0, 32'd10, 32'd0);
    chk("latency edge N+1", 32'(out_valid), 32'd1);
    drain();
    if (fire_cyc.size() >= 2)
      chk("no bubble", 32'(fire_cyc[1] - fire_cyc[0]), 32'd1);
    else
      chk("fire count", 32'(fire_cyc.size()), 32'd2);
    rd(4'd3, 32'd10);
    rd(4'd1, 32'd5);
    drain();

    // stall with three offers
    out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 3; k++) begin
      set_in(OP_PASS, VEC_W, 4'd0, 4'd0, 4'd0, 4'd0, sy[acc],
             4'd0, 2'b01, 1'b1, sk[acc]);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({sk[acc], 32'd0});
        acc++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("stall accepted", 32'(acc), 32'd2);
    chk("stall in_ready", 32'(in_ready), 32'd0);
    chk("stall y1 first", y1_data, 32'd11);
    @(posedge clk);
    #1;
    chk("stall y1 stable", y1_data, 32'd11);
    chk("stall no writeback", dut.rf_q[5], 32'd0);
    out_ready = 1'b1;
    drain();
    wr(4'd7, 32'd13);
    rd(4'd5, 32'd11);
    rd(4'd6, 32'd12);
    rd(4'd7, 32'd13);
    drain();

    // lane behaviour
    wr(4'd1, 32'h0000_00FF);
    wr(4'd2, 32'h0000_0001);
    issue(OP_ADD, VEC_B, 4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0,
          2'b00, 1'b0, 32'd0, 32'h0000_0000, 32'd0);
    issue(OP_ADD, VEC_W, 4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0,
          2'b00, 1'b0, 32'd0, 32'h0000_0100, 32'd0);
    issue(OP_ADD, VEC_H, 4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0,
          2'b00, 1'b0, 32'd0, 32'h0000_0100, 32'd0);
    issue(OP_SUB, VEC_B, 4'd1, 4'd2, 4'd2, 4'd1, 4'd0, 4'd0,
          2'b00, 1'b0, 32'd0, 32'h0000_00FE, 32'h0000_0002);
    issue(OP_SUB, VEC_W, 4'd1, 4'd2, 4'd2, 4'd1, 4'd0, 4'd0,
          2'b00, 1'b0, 32'd0, 32'h0000_00FE, 32'hFFFF_FF02);
    issue(OP_SHL, VEC_B, 4'd1, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0,
          2'b00, 1'b0, 32'd0, 32'h0000_00FE, 32'h0000_0080);
    issue(OP_SHL, VEC_W, 4'd1, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0,
          2'b00, 1'b0, 32'd0, 32'h0000_01FE, 32'h8000_0000);
    issue(OP_AND, VEC_W, 4'd0, 4'd1, 4'd1, 4'd2, 4'd0, 4'd0,
          2'b00, 1'b1, 32'hF0F0_1234, 32'h0000_0034, 32'h1);
    issue(OP_OR, VEC_W, 4'd0, 4'd1, 4'd1, 4'd2, 4'd0, 4'd0,
          2'b00, 1'b1, 32'hF0F0_1234, 32'hF0F0_12FF, 32'hFF);
    issue(OP_XOR, VEC_W, 4'd0, 4'd1, 4'd1, 4'd2, 4'd0, 4'd0,
          2'b00, 1'b1, 32'hF0F0_1234, 32'hF0F0_12CB, 32'hFE);
    issue(OP_SHR, VEC_H, 4'd0, 4'd2, 4'd1, 4'd2, 4'd0, 4'd0,
          2'b00, 1'b1, 32'h8000_8000, 32'h8000_4000, 32'h7F);
    issue(OP_SHR, 2'b11, 4'd0, 4'd2, 4'd1, 4'd2, 4'd0, 4'd0,
          2'b00, 1'b1, 32'h8000_8000, 32'h4000_4000, 32'h7F);
    drain();

    // dual write to one register, and writes to r0
    wr(4'd8, 32'd9);
    issue(OP_PASS, VEC_W, 4'd0, 4'd0, 4'd8, 4'd0, 4'd4, 4'd4,
          2'b11, 1'b1, 32'd7, 32'd7, 32'd9);
    rd(4'd4, 32'd9);
    drain();
    rd(4'd4, 32'd9);
    wr(4'd0, 32'd33);
    rd(4'd0, 32'd0);
    drain();
    rd(4'd0, 32'd0);
    drain();
    chk("r0 storage", dut.rf_q[0], 32'd0);

    // reset while a result is being handed over
    out_ready = 1'b0;
    wr(4'd9, 32'd77);
    acc = 0;
    for (int t = 0; t < 20 && acc == 0; t++) begin
      @(negedge clk);
      if (out_valid) acc = 1;
    end
    chk("mid-reset setup", 32'(acc), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("in_ready in reset", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("mid-reset out_valid", 32'(out_valid), 32'd0);
    chk("mid-reset y1_data", y1_data, 32'd0);
    nz = 0;
    for (int i = 0; i < 16; i++)
      if (dut.rf_q[i] !== '0) nz++;
    chk("mid-reset regs zero", 32'(nz), 32'd0);
    rst_n = 1'b1;
    rd(4'd9, 32'd0);
    rd(4'd1, 32'd0);
    drain();

    chk("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
